// File: rtl/ring_mon_pkg.sv
// Shared types and constants for the ring counter monitor: FSM state encoding
// and rotation direction selectors.
package ring_mon_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int DIR_LSB2MSB = 0;
    localparam int DIR_MSB2LSB = 1;

    // good_run only has to reach LOCK_CNT, which is at most 15
    localparam int GOOD_RUN_W = 4;

endpackage

// File: rtl/onehot_chk.sv
// Combinational one-hot classifier: flags whether exactly one bit of cnt is set
// and reports the index of that bit.
module onehot_chk #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] cnt,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        legal = 1'b0;
        idx   = '0;
        if (cnt != '0) begin
            legal = ((cnt & (cnt - WIDTH'(1))) == '0);
        end
        // idx is only meaningful when legal; for multi-hot it is the top set bit
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ring_cntr_monitor.sv
// Ring counter monitor: tracks a one-hot ring counter, locks after LOCK_CNT
// consecutive correct rotations, reports phase, revolutions and sequence errors.
module ring_cntr_monitor
    import ring_mon_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DIR      = 0,
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8,
    parameter int ERR_W    = 8,
    localparam int IDX_W   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt,
    output logic             locked,
    output logic [IDX_W-1:0] phase_idx,
    output logic             rev_pulse,
    output logic [REV_W-1:0] rev_cnt,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output state_t           dbg_state
);

    localparam logic [WIDTH-1:0] REV_PT = (DIR == DIR_LSB2MSB) ?
                                          WIDTH'(1) : {1'b1, {(WIDTH-1){1'b0}}};

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        ref_q, ref_d;
    logic [GOOD_RUN_W-1:0]   run_q, run_d, run_inc;
    logic [WIDTH-1:0]        exp_val;
    logic                    legal, match;
    logic [IDX_W-1:0]        idx;
    logic                    rev_hit, err_hit;

    onehot_chk #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_onehot_chk (
        .cnt   (cnt),
        .legal (legal),
        .idx   (idx)
    );

    always_comb begin
        if (DIR == DIR_LSB2MSB) begin
            exp_val = {ref_q[WIDTH-2:0], ref_q[WIDTH-1]};
        end else begin
            exp_val = {ref_q[0], ref_q[WIDTH-1:1]};
        end
    end

    // A stalled counter compares against the rotated ref and so mismatches
    assign match   = (cnt == exp_val);
    assign run_inc = run_q + GOOD_RUN_W'(1);

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        run_d   = run_q;
        rev_hit = 1'b0;
        err_hit = 1'b0;
        if (en) begin
            case (state_q)
                SEARCH: begin
                    if (legal) begin
                        state_d = TRACK;
                        ref_d   = cnt;
                        run_d   = '0;
                    end
                end
                TRACK: begin
                    if (match) begin
                        ref_d = cnt;
                        run_d = run_inc;
                        if (run_inc == GOOD_RUN_W'(LOCK_CNT)) begin
                            state_d = LOCKED;
                        end
                    end else if (legal) begin
                        ref_d = cnt;
                        run_d = '0;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        ref_d   = cnt;
                        rev_hit = (cnt == REV_PT);
                    end else begin
                        err_hit = 1'b1;
                        if (legal) begin
                            state_d = TRACK;
                            ref_d   = cnt;
                            run_d   = '0;
                        end else begin
                            state_d = SEARCH;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SEARCH;
            ref_q     <= '0;
            run_q     <= '0;
            locked    <= 1'b0;
            phase_idx <= '0;
            rev_pulse <= 1'b0;
            rev_cnt   <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            run_q     <= run_d;
            locked    <= (state_d == LOCKED);
            rev_pulse <= rev_hit;
            err_pulse <= err_hit;
            if (en && legal) begin
                phase_idx <= idx;
            end
            if (rev_hit) begin
                rev_cnt <= rev_cnt + REV_W'(1);
            end
            if (err_hit && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_ring_cntr_monitor.sv
// Bench for ring_cntr_monitor (WIDTH=4, DIR=0, LOCK_CNT=2): directed vector table,
// async reset checks, randomized run against an index-arithmetic model, saturation.
module tb_ring_cntr_monitor;

    localparam int W    = 4;
    localparam int LOCK = 2;
    localparam int OW   = 23;

    typedef struct {
        bit         en;
        logic [3:0] cnt;
        bit         lk;
        int         ph;
        bit         rp;
        int         rc;
        bit         ep;
        int         ec;
        int         st;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  cnt;
    logic        locked;
    logic [1:0]  phase_idx;
    logic        rev_pulse;
    logic [7:0]  rev_cnt;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [OW-1:0] exp_q[$];
    vec_t          tbl[$];

    // reference model state: index-based view of the ring
    bit m_have, m_locked, m_revp, m_errp;
    int m_ref, m_run, m_phase, m_revc, m_errc;

    ring_cntr_monitor #(
        .WIDTH(W), .DIR(0), .LOCK_CNT(LOCK), .REV_W(8), .ERR_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cnt       (cnt),
        .locked    (locked),
        .phase_idx (phase_idx),
        .rev_pulse (rev_pulse),
        .rev_cnt   (rev_cnt),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [OW-1:0] dut_pack();
        return {dbg_state, locked, phase_idx, rev_pulse, rev_cnt, err_pulse, err_cnt};
    endfunction

    function automatic logic [OW-1:0] mk_pack(int st, bit lk, int ph, bit rp, int rc,
                                              bit ep, int ec);
        return {2'(st), lk, 2'(ph), rp, 8'(rc), ep, 8'(ec)};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, expv);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_locked = 0; m_revp = 0; m_errp = 0;
        m_ref = 0; m_run = 0; m_phase = 0; m_revc = 0; m_errc = 0;
    endtask

    task automatic model_step(input bit e, input logic [3:0] c);
        bit legal, ok;
        int idx;
        m_revp = 0;
        m_errp = 0;
        if (!e) return;
        legal = ($countones(c) == 1);
        idx = 0;
        for (int i = 0; i < W; i++) if (c[i]) idx = i;
        ok = m_have && legal && (idx == (m_ref + 1) % W);
        if (legal) m_phase = idx;
        if (!m_have) begin
            if (legal) begin m_have = 1; m_ref = idx; m_run = 0; end
        end else if (m_locked) begin
            if (ok) begin
                m_ref = idx;
                if (idx == 0) begin m_revp = 1; m_revc = (m_revc + 1) % 256; end
            end else begin
                m_errp = 1;
                if (m_errc < 255) m_errc++;
                m_locked = 0;
                if (legal) begin m_ref = idx; m_run = 0; end
                else m_have = 0;
            end
        end else begin
            if (ok) begin
                m_ref = idx;
                m_run++;
                if (m_run == LOCK) m_locked = 1;
            end else if (legal) begin
                m_ref = idx; m_run = 0;
            end else begin
                m_have = 0;
            end
        end
    endtask

    function automatic logic [OW-1:0] model_pack();
        int st;
        st = !m_have ? 0 : (m_locked ? 2 : 1);
        return mk_pack(st, m_locked, m_phase, m_revp, m_revc, m_errp, m_errc);
    endfunction

    // driver: apply at negedge, model on posedge, score #1 later
    task automatic drive(input bit e, input logic [3:0] c);
        logic [OW-1:0] expv;
        @(negedge clk);
        en  = e;
        cnt = c;
        @(posedge clk);
        model_step(e, c);
        exp_q.push_back(model_pack());
        #1;
        expv = exp_q.pop_front();
        chk("scoreboard", 64'(dut_pack()), 64'(expv));
    endtask

    function automatic void add(bit e, logic [3:0] c, bit lk, int ph, bit rp, int rc,
                                bit ep, int ec, int st);
        vec_t v;
        v.en = e; v.cnt = c; v.lk = lk; v.ph = ph; v.rp = rp; v.rc = rc;
        v.ep = ep; v.ec = ec; v.st = st;
        tbl.push_back(v);
    endfunction

    initial begin
        bit         e;
        int         ch, pos;
        logic [3:0] c;

        // directed table, starting from reset release
        add(1, 4'b0001, 0, 0, 0, 0, 0, 0, 1);
        add(1, 4'b0010, 0, 1, 0, 0, 0, 0, 1);
        add(1, 4'b0100, 1, 2, 0, 0, 0, 0, 2);
        add(1, 4'b1000, 1, 3, 0, 0, 0, 0, 2);
        add(1, 4'b0001, 1, 0, 1, 1, 0, 0, 2);
        for (int r = 0; r < 4; r++) begin
            add(1, 4'b0010, 1, 1, 0, 1 + r, 0, 0, 2);
            add(1, 4'b0100, 1, 2, 0, 1 + r, 0, 0, 2);
            add(1, 4'b1000, 1, 3, 0, 1 + r, 0, 0, 2);
            add(1, 4'b0001, 1, 0, 1, 2 + r, 0, 0, 2);
        end
        add(1, 4'b0011, 0, 0, 0, 5, 1, 1, 0);
        add(1, 4'b0100, 0, 2, 0, 5, 0, 1, 1);
        add(1, 4'b1000, 0, 3, 0, 5, 0, 1, 1);
        add(1, 4'b0001, 1, 0, 0, 5, 0, 1, 2);
        add(1, 4'b0010, 1, 1, 0, 5, 0, 1, 2);
        add(1, 4'b1000, 0, 3, 0, 5, 1, 2, 1);
        add(1, 4'b0001, 0, 0, 0, 5, 0, 2, 1);
        add(1, 4'b0001, 0, 0, 0, 5, 0, 2, 1);
        add(1, 4'b0010, 0, 1, 0, 5, 0, 2, 1);
        add(1, 4'b0100, 1, 2, 0, 5, 0, 2, 2);
        add(0, 4'b0000, 1, 2, 0, 5, 0, 2, 2);
        add(0, 4'b1111, 1, 2, 0, 5, 0, 2, 2);
        add(0, 4'b0001, 1, 2, 0, 5, 0, 2, 2);
        add(0, 4'b1000, 1, 2, 0, 5, 0, 2, 2);
        add(0, 4'b0110, 1, 2, 0, 5, 0, 2, 2);
        add(1, 4'b1000, 1, 3, 0, 5, 0, 2, 2);
        add(1, 4'b0000, 0, 3, 0, 5, 1, 3, 0);
        add(1, 4'b0101, 0, 3, 0, 5, 0, 3, 0);
        add(1, 4'b0010, 0, 1, 0, 5, 0, 3, 1);

        // reset: outputs must be zero even while the clock runs
        rst = 1'b0;
        en  = 1'b1;
        cnt = 4'b0001;
        model_reset();
        #1;
        chk("reset_async", 64'(dut_pack()), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", 64'(dut_pack()), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].cnt);
            chk($sformatf("vec%0d", i), 64'(dut_pack()),
                64'(mk_pack(tbl[i].st, tbl[i].lk, tbl[i].ph, tbl[i].rp, tbl[i].rc,
                            tbl[i].ep, tbl[i].ec)));
        end

        // relock from TRACK at 0010, then reset between edges
        drive(1, 4'b0100);
        drive(1, 4'b1000);
        chk("relock_before_rst", 64'(locked), 64'(1));
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_locked", 64'(locked), 64'(0));
        chk("midrst_rev_cnt", 64'(rev_cnt), 64'(0));
        chk("midrst_err_cnt", 64'(err_cnt), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1, 4'b0100);
        chk("post_rst_search", 64'(dbg_state), 64'(1));

        // randomized ring with skips, stalls, junk and enable gaps
        pos = 2;
        for (int i = 0; i < 1500; i++) begin
            e  = ($urandom_range(0, 7) != 0);
            ch = $urandom_range(0, 15);
            if (!e || ch == 0) begin
                c = 4'($urandom_range(0, 15));
            end else if (ch == 1) begin
                c = 4'(1 << pos);
            end else if (ch == 2) begin
                pos = (pos + 2) % W;
                c = 4'(1 << pos);
            end else begin
                pos = (pos + 1) % W;
                c = 4'(1 << pos);
            end
            drive(e, c);
        end

        // error counter saturation: 300 lock/error cycles
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1, 4'b0001);
        drive(1, 4'b0010);
        drive(1, 4'b0100);
        for (int i = 0; i < 300; i++) begin
            drive(1, 4'b0001);
            drive(1, 4'b0010);
            drive(1, 4'b0100);
        end
        chk("err_sat", 64'(err_cnt), 64'(255));
        chk("sat_locked", 64'(locked), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
